lsu_ctrl: RTL and testbench

- Multi-cycle load/store controller; the CPU-side initiator that drives the 4 KB byte-enable data memory.
- Accepts one load or store request from the datapath and latches it.
- Generates the word address, byte-enable pattern, write strobe and write data in the memory's conventions.
- Extracts and sign/zero-extends load data, then signals completion with a one-cycle done pulse.

---
 rtl/lsu_ctrl_if.sv | 28 ++
 rtl/lsu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory side bus of the load/store controller.
// The master drives word address, write data, write strobe and byte enables;
// the slave (the 4 KB byte-enable memory) returns combinational read data.
interface lsu_ctrl_if #(
   parameter int AW = 10
) ();
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_din;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [31:0]   dm_dout;

   modport master (
      output dm_addr,
      output dm_din,
      output dm_we,
      output dm_be,
      input  dm_dout
   );

   modport slave (
      input  dm_addr,
      input  dm_din,
      input  dm_we,
      input  dm_be,
      output dm_dout
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller (IDLE -> ISSUE -> DONE).
// Latches one request, drives the byte-enable data memory for exactly one
// ISSUE cycle, extracts and sign/zero-extends load data and pulses done.
// Build option: define LSU_MISALIGN_EXC_EN to flag misaligned half/word
// accesses (no memory access, adel/ades raised with done). Without it the
// low address bits are ignored for alignment and every access proceeds.
module lsu_ctrl #(
   parameter int          AW        = 10,
   parameter logic [31:0] RST_RDATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        st,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        adel,
   output logic        ades,
   lsu_ctrl_if.master  dm
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    op_q;
   logic          st_q;
   logic          accept;
   logic          err;
   logic          unused_addr_bits;

   // Byte-enable pattern in the memory's encoding; half uses addr[1] only.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         2'b00: begin
            case (lo)
               2'b00:   be = 4'b0001;
               2'b01:   be = 4'b0010;
               2'b10:   be = 4'b0100;
               2'b11:   be = 4'b1000;
               default: be = 4'b0001;
            endcase
         end
         2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Lane selection plus sign (zext=0) or zero (zext=1) extension of load data.
   function automatic logic [31:0] load_ext(input logic [31:0] data, input logic [1:0] size,
                                            input logic [1:0] lo, input logic zext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'b00:   b = data[7:0];
         2'b01:   b = data[15:8];
         2'b10:   b = data[23:16];
         2'b11:   b = data[31:24];
         default: b = data[7:0];
      endcase
      h = lo[1] ? data[31:16] : data[15:0];
      case (size)
         2'b00:   r = zext ? {24'h00_0000, b} : {{24{b[7]}}, b};
         2'b01:   r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
         default: r = data;
      endcase
      return r;
   endfunction

`ifdef LSU_MISALIGN_EXC_EN
   // Half must be 2-byte aligned, word (and reserved size) 4-byte aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = lo[0];
         default: m = (lo != 2'b00);
      endcase
      return m;
   endfunction

   assign err = misaligned(op_q[1:0], addr_q[1:0]);
`else
   assign err = 1'b0;
`endif

   // Upper address bits are beyond the 4 KB memory and wrap.
   assign unused_addr_bits = ^addr[31:AW+2];

   assign accept = (state == IDLE) & req;

   // Memory bus is driven from latched fields; the strobe is a decode of registered state.
   assign dm.dm_addr = addr_q[AW+1:2];
   assign dm.dm_din  = wdata_q;
   assign dm.dm_we   = (state == ISSUE) & st_q & ~err;
   assign dm.dm_be   = byte_en(op_q[1:0], addr_q[1:0]);

   // Next-state logic for the three-phase access sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         ISSUE:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register with registered busy/done decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
      end
   end

   // Request capture; fields hold while the access is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= 32'h0000_0000;
         op_q    <= 3'b000;
         st_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= addr[AW+1:0];
         wdata_q <= wdata;
         op_q    <= op;
         st_q    <= st;
      end
   end

   // Load result captured at the end of ISSUE; held across stores and errored loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= RST_RDATA;
      end else if ((state == ISSUE) && !st_q && !err) begin
         rdata <= load_ext(dm.dm_dout, op_q[1:0], addr_q[1:0], op_q[2]);
      end
   end

`ifdef LSU_MISALIGN_EXC_EN
   // Address-error flags, raised for the DONE cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adel <= 1'b0;
         ades <= 1'b0;
      end else begin
         adel <= (state == ISSUE) & err & ~st_q;
         ades <= (state == ISSUE) & err & st_q;
      end
   end
`else
   assign adel = 1'b0;
   assign ades = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 4 KB byte-enable memory
// and a scoreboard queue of expected completion results.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        st;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        adel;
   logic        ades;

   lsu_ctrl_if #(.AW(10)) dm_bus ();

   lsu_ctrl #(.AW(10), .RST_RDATA(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .st    (st),
      .op    (op),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .adel  (adel),
      .ades  (ades),
      .dm    (dm_bus.master)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        adel;
      logic        ades;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem [0:1023];
   bit          mem_ready = 1'b0;
   int          we_cnt = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_bus.dm_dout = mem[dm_bus.dm_addr];

   // Behavioural memory: preload once, then byte-enable writes (low byte/half of din).
   always @(posedge clk) begin
      logic [31:0] w;
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0000_0000;
         mem[4]    <= 32'hCAFE_0004;
         mem_ready <= 1'b1;
      end else if (dm_bus.dm_we) begin
         w = mem[dm_bus.dm_addr];
         for (int k = 0; k < 4; k++) begin
            if (dm_bus.dm_be[k]) begin
               if (dm_bus.dm_be == 4'hF)
                  w[8*k +: 8] = dm_bus.dm_din[8*k +: 8];
               else if (dm_bus.dm_be == 4'h3 || dm_bus.dm_be == 4'hC)
                  w[8*k +: 8] = dm_bus.dm_din[8*(k%2) +: 8];
               else
                  w[8*k +: 8] = dm_bus.dm_din[7:0];
            end
         end
         mem[dm_bus.dm_addr] <= w;
      end
   end

   // Count write-strobe cycles as seen by the memory.
   always @(posedge clk) begin
      if (rst_n && dm_bus.dm_we) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_rdata"}, rdata, e.rdata);
         check({tag, "_adel"}, {31'd0, adel}, {31'd0, e.adel});
         check({tag, "_ades"}, {31'd0, ades}, {31'd0, e.ades});
      end
   endtask

   // One complete request: drive, check the ISSUE cycle, wait for done, score.
   task automatic do_req(input string tag, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] exp_be, input logic exp_we,
                         input logic [31:0] exp_rd, input logic exp_adel, input logic exp_ades);
      int   we0;
      int   lat;
      exp_t e;
      @(negedge clk);
      req = 1'b1; st = s; op = o; addr = a; wdata = wd;
      e.rdata = exp_rd; e.adel = exp_adel; e.ades = exp_ades;
      sb_q.push_back(e);
      we0 = we_cnt;
      @(negedge clk);
      req = 1'b0;
      check({tag, "_issue_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_issue_done"}, {31'd0, done}, 32'd0);
      check({tag, "_be"}, {28'd0, dm_bus.dm_be}, {28'd0, exp_be});
      check({tag, "_we"}, {31'd0, dm_bus.dm_we}, {31'd0, exp_we});
      check({tag, "_dm_addr"}, {22'd0, dm_bus.dm_addr}, {22'd0, a[11:2]});
      check({tag, "_dm_din"}, dm_bus.dm_din, wd);
      lat = 1;
      while (!done && lat < 5) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      check({tag, "_latency"}, lat, 32'd2);
      pop_check(tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_we_cycles"}, we_cnt - we0, {31'd0, exp_we});
   endtask

   initial begin
      int          dones;
      logic [31:0] exp8;
      exp_t        e;
      rst_n = 1'b0; req = 1'b0; st = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we", {31'd0, dm_bus.dm_we}, 32'd0);
      check("rst_rdata", rdata, 32'h0000_0000);
      check("rst_adel", {31'd0, adel}, 32'd0);
      check("rst_ades", {31'd0, ades}, 32'd0);
      check("rst_dm_addr", {22'd0, dm_bus.dm_addr}, 32'd0);
      check("rst_dm_din", dm_bus.dm_din, 32'd0);
      rst_n = 1'b1;

      // Reset asserted in the middle of a store's ISSUE cycle.
      @(negedge clk);
      req = 1'b1; st = 1'b1; op = 3'b010; addr = 32'h10; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      req = 1'b0;
      check("rstmid_we_before", {31'd0, dm_bus.dm_we}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_we_drop", {31'd0, dm_bus.dm_we}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_rdata", rdata, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_mem4", mem[4], 32'hCAFE_0004);

      // Word store/load.
      do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
      check("sw20_mem", mem[8], 32'h1122_3344);
      do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 4'b1111, 1'b0, 32'h1122_3344, 1'b0, 1'b0);

      // Byte store and signed/unsigned byte loads.
      do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h0000_00A5, 4'b0010, 1'b1, 32'h1122_3344, 1'b0, 1'b0);
      check("sb21_mem", mem[8], 32'h1122_A544);
      do_req("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 4'b0010, 1'b0, 32'hFFFF_FFA5, 1'b0, 1'b0);
      do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 4'b0010, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
      do_req("lb23", 1'b0, 3'b000, 32'h23, 32'h0, 4'b1000, 1'b0, 32'h0000_0011, 1'b0, 1'b0);

      // Half store and signed/unsigned half loads.
      do_req("sh32", 1'b1, 3'b001, 32'h32, 32'h0000_8001, 4'b1100, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
      check("sh32_mem", mem[12], 32'h8001_0000);
      do_req("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 4'b1100, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0);
      do_req("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 4'b1100, 1'b0, 32'h0000_8001, 1'b0, 1'b0);

      // Address wrap at 4 KB.
      do_req("sw_wrap", 1'b1, 3'b010, 32'h0000_1004, 32'h0BAD_F00D, 4'b1111, 1'b1, 32'h0000_8001, 1'b0, 1'b0);
      check("sw_wrap_mem", mem[1], 32'h0BAD_F00D);
      do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFF_F004, 32'h0, 4'b1111, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);

      // Misaligned accesses.
`ifdef LSU_MISALIGN_EXC_EN
      do_req("lw22_mis", 1'b0, 3'b010, 32'h22, 32'h0, 4'b1111, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0);
      do_req("sh23_mis", 1'b1, 3'b001, 32'h23, 32'h0000_BEEF, 4'b1100, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
      exp8 = 32'h1122_A544;
`else
      do_req("lw22_aln", 1'b0, 3'b010, 32'h22, 32'h0, 4'b1111, 1'b0, 32'h1122_A544, 1'b0, 1'b0);
      do_req("sh23_aln", 1'b1, 3'b001, 32'h23, 32'h0000_BEEF, 4'b1100, 1'b1, 32'h1122_A544, 1'b0, 1'b0);
      exp8 = 32'hBEEF_A544;
`endif
      check("mis_mem8", mem[8], exp8);

      // req pulsed during ISSUE and DONE of an active load is ignored.
      @(negedge clk);
      req = 1'b1; st = 1'b0; op = 3'b010; addr = 32'h20;
      e.rdata = exp8; e.adel = 1'b0; e.ades = 1'b0;
      sb_q.push_back(e);
      dones = 0;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         if (n == 1) addr = 32'h24;
         if (n == 3) req = 1'b0;
         if (n == 2) check("pulse_dm_addr", {22'd0, dm_bus.dm_addr}, 32'd8);
         if (done) begin
            dones++;
            pop_check("pulse");
         end
      end
      check("pulse_done_count", dones, 32'd1);
      check("pulse_busy_end", {31'd0, busy}, 32'd0);

      // req held high: one acceptance every 3 cycles.
      @(negedge clk);
      req = 1'b1; st = 1'b0; op = 3'b010; addr = 32'h20;
      for (int i = 0; i < 3; i++) begin
         e.rdata = exp8; e.adel = 1'b0; e.ades = 1'b0;
         sb_q.push_back(e);
      end
      dones = 0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (n == 9) req = 1'b0;
         check("hold_done_pattern", {31'd0, done}, {31'd0, (n % 3) == 2});
         if (done) begin
            dones++;
            pop_check("hold");
         end
      end
      check("hold_done_count", dones, 32'd3);
      repeat (2) @(negedge clk);
      check("hold_busy_end", {31'd0, busy}, 32'd0);
      check("sb_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
